// File: rtl/clk_div_gen.sv
// Multi-channel divided-clock generator: per-channel 50 % duty square waves with programmable
// half-period, rising-edge ticks, glitch-free ratio updates and a global phase-align sync.
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_CH-1:0]                              en,
  input  logic                                           sync,
  input  logic                                           cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                               cfg_div,
  output logic [NUM_CH-1:0]                              clk_out,
  output logic [NUM_CH-1:0]                              tick,
  output logic                                           cfg_err
);

  localparam int unsigned     CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]   NumCh  = NUM_CH[CH_W:0];
  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] One    = DIV_W'(1);

  logic [DIV_W-1:0]  cnt_q     [NUM_CH];
  logic [DIV_W-1:0]  cnt_d     [NUM_CH];
  logic [DIV_W-1:0]  div_act_q [NUM_CH];
  logic [DIV_W-1:0]  div_act_d [NUM_CH];
  logic [DIV_W-1:0]  div_shd_q [NUM_CH];
  logic [DIV_W-1:0]  div_shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_bad;
  logic [NUM_CH-1:0] ch_wr, ch_last, ch_load;

  always_comb begin
    cfg_bad   = cfg_we && (({1'b0, cfg_ch} >= NumCh) || (cfg_div == '0));
    cfg_err_d = cfg_bad;
    ch_wr     = '0;
    ch_last   = '0;
    ch_load   = '0;
    pend_d    = pend_q;
    out_d     = out_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_act_d[i] = div_act_q[i];
      div_shd_d[i] = div_shd_q[i];
      ch_wr[i]     = cfg_we && !cfg_bad && (cfg_ch == CH_W'(i));
      ch_last[i]   = (cnt_q[i] == (div_act_q[i] - One));

      // A load point is any idle edge, a sync in RUN, or the 1->0 toggle ending a full period.
      if (!en[i]) begin
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
        ch_load[i] = 1'b1;
      end else if (sync) begin
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
        ch_load[i] = 1'b1;
      end else if (ch_last[i]) begin
        cnt_d[i]   = '0;
        out_d[i]   = ~out_q[i];
        tick_d[i]  = ~out_q[i];
        ch_load[i] = out_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + One;
      end

      if (ch_wr[i]) begin
        div_shd_d[i] = cfg_div;
        if (ch_load[i]) begin
          div_act_d[i] = cfg_div;
          pend_d[i]    = 1'b0;
        end else begin
          pend_d[i] = 1'b1;
        end
      end else if (ch_load[i] && pend_q[i]) begin
        div_act_d[i] = div_shd_q[i];
        pend_d[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DivRst;
        div_shd_q[i] <= DivRst;
      end
      pend_q    <= '0;
      out_q     <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_act_q[i] <= div_act_d[i];
        div_shd_q[i] <= div_shd_d[i];
      end
      pend_q    <= pend_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: defaults, multi-ratio, glitch-free update, bypass, sync,
// config errors and asynchronous reset mid-run.
module tb_clk_div_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       cfg_err;

  logic [2:0] en2;
  logic       sync2;
  logic       cfg_we2;
  logic [1:0] cfg_ch2;
  logic [7:0] cfg_div2;
  logic [2:0] clk_out2;
  logic [2:0] tick2;
  logic       cfg_err2;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_gen #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
  );

  // Three channels so that an out-of-range channel index is representable on cfg_ch.
  clk_div_gen #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .sync(sync2), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2),
    .cfg_div(cfg_div2), .clk_out(clk_out2), .tick(tick2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  // Output after the n-th edge counted from the first RUN edge (n=1), half-period d.
  function automatic logic exp_out(input int n, input int d);
    if (n < d) return 1'b0;
    return (((n - d) / d) % 2) == 0;
  endfunction

  function automatic logic exp_tick(input int n, input int d);
    return (n >= d) && (((n - d) % (2 * d)) == 0);
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] div);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = div;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] e;
    logic [3:0] t;
    #2;
    n_checks++;
    if (clk_out !== 4'b0) begin
      n_fail++; $display("FAIL reset_clk_out got %b want 0000", clk_out);
    end
    n_checks++;
    if (tick !== 4'b0) begin
      n_fail++; $display("FAIL reset_tick got %b want 0000", tick);
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 4'b0001;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      e = {3'b000, exp_out(n, 5)};
      t = {3'b000, exp_tick(n, 5)};
      n_checks++;
      if (clk_out !== e) begin
        n_fail++; $display("FAIL default_clk_out n=%0d got %b want %b", n, clk_out, e);
      end
      n_checks++;
      if (tick !== t) begin
        n_fail++; $display("FAIL default_tick n=%0d got %b want %b", n, tick, t);
      end
    end
  endtask

  task automatic test_multi_ratio;
    int d [4] = '{1, 2, 3, 7};
    int want [4] = '{42, 21, 14, 6};
    int cnt [4] = '{0, 0, 0, 0};
    logic [3:0] e;
    en = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (clk_out !== 4'b0) begin
      n_fail++; $display("FAIL idle_clk_out got %b want 0000", clk_out);
    end
    cfg_write(2'd0, 8'd1);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL valid_write_cfg_err got %b want 0", cfg_err);
    end
    cfg_write(2'd1, 8'd2);
    cfg_write(2'd2, 8'd3);
    cfg_write(2'd3, 8'd7);
    en = 4'hF;
    for (int n = 1; n <= 84; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        e[i] = exp_out(n, d[i]);
        if (tick[i] === 1'b1) cnt[i]++;
      end
      n_checks++;
      if (clk_out !== e) begin
        n_fail++; $display("FAIL multi_clk_out n=%0d got %b want %b", n, clk_out, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cnt[i] !== want[i]) begin
        n_fail++; $display("FAIL multi_tick_count ch=%0d got %0d want %0d", i, cnt[i], want[i]);
      end
    end
  endtask

  task automatic test_glitch_free;
    logic e [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    en = 4'b0000;
    cfg_write(2'd0, 8'd5);
    en = 4'b0001;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      n_checks++;
      if (clk_out[0] !== e[n-1]) begin
        n_fail++; $display("FAIL glitch_clk_out n=%0d got %b want %b", n, clk_out[0], e[n-1]);
      end
      if (n == 6) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
      end
      if (n == 7) cfg_we = 1'b0;
    end
  endtask

  task automatic test_bypass;
    logic e [12] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    en = 4'b0000;
    cfg_write(2'd0, 8'd2);
    en = 4'b0001;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      n_checks++;
      if (clk_out[0] !== e[n-1]) begin
        n_fail++; $display("FAIL bypass_clk_out n=%0d got %b want %b", n, clk_out[0], e[n-1]);
      end
      if (n == 3) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
      end
      if (n == 4) cfg_we = 1'b0;
    end
  endtask

  task automatic test_sync;
    logic [3:0] e;
    logic [3:0] t;
    en = 4'b0000;
    cfg_write(2'd0, 8'd3);
    cfg_write(2'd1, 8'd4);
    en = 4'b0011;
    for (int n = 1; n <= 4; n++) @(negedge clk);
    n_checks++;
    if (clk_out !== 4'b0011) begin
      n_fail++; $display("FAIL sync_pre_clk_out got %b want 0011", clk_out);
    end
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    n_checks++;
    if (clk_out !== 4'b0000) begin
      n_fail++; $display("FAIL sync_low_clk_out got %b want 0000", clk_out);
    end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      e = {2'b00, exp_out(n, 4), exp_out(n, 3)};
      t = {2'b00, exp_tick(n, 4), exp_tick(n, 3)};
      n_checks++;
      if (clk_out !== e) begin
        n_fail++; $display("FAIL sync_clk_out n=%0d got %b want %b", n, clk_out, e);
      end
      n_checks++;
      if (tick !== t) begin
        n_fail++; $display("FAIL sync_tick n=%0d got %b want %b", n, tick, t);
      end
    end
  endtask

  task automatic test_errors;
    logic [2:0] e2;
    logic [3:0] e;
    cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_div2 = 8'd2;
    @(negedge clk);
    cfg_we2 = 1'b0;
    n_checks++;
    if (cfg_err2 !== 1'b1) begin
      n_fail++; $display("FAIL bad_ch_cfg_err got %b want 1", cfg_err2);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_err2 !== 1'b0) begin
      n_fail++; $display("FAIL bad_ch_cfg_err_clear got %b want 0", cfg_err2);
    end
    en2 = 3'b001;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      e2 = {2'b00, exp_out(n, 5)};
      n_checks++;
      if (clk_out2 !== e2) begin
        n_fail++; $display("FAIL bad_ch_clk_out n=%0d got %b want %b", n, clk_out2, e2);
      end
    end
    en2 = 3'b000;
    en  = 4'b0000;
    cfg_write(2'd1, 8'd0);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL zero_div_cfg_err got %b want 1", cfg_err);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL zero_div_cfg_err_clear got %b want 0", cfg_err);
    end
    en = 4'b0010;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      e = {2'b00, exp_out(n, 4), 1'b0};
      n_checks++;
      if (clk_out !== e) begin
        n_fail++; $display("FAIL zero_div_clk_out n=%0d got %b want %b", n, clk_out, e);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] e;
    en = 4'b0000;
    cfg_write(2'd0, 8'd3);
    en = 4'b0001;
    for (int n = 1; n <= 3; n++) @(negedge clk);
    n_checks++;
    if (clk_out !== 4'b0001) begin
      n_fail++; $display("FAIL mid_run_high got %b want 0001", clk_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (clk_out !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_clk_out got %b want 0000", clk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      e = {3'b000, exp_out(n, 5)};
      n_checks++;
      if (clk_out !== e) begin
        n_fail++; $display("FAIL post_reset_clk_out n=%0d got %b want %b", n, clk_out, e);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 4'b0000;
    sync     = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_div  = 8'd0;
    en2      = 3'b000;
    sync2    = 1'b0;
    cfg_we2  = 1'b0;
    cfg_ch2  = 2'd0;
    cfg_div2 = 8'd0;
    test_reset();
    test_multi_ratio();
    test_glitch_free();
    test_bypass();
    test_sync();
    test_errors();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
